alu_result_sel: RTL and testbench
=================================

ALU_RESULT_SEL -- requirements
Module: alu_result_sel

Interface
REQ-001 SHALL provide parameter WIDTH, default 8: result data width in bits, legal 1..64.
REQ-002 SHALL provide parameter NCH, default 5: number of operation result channels, legal 1..16; channel 0 = highest priority (0 cmp, 1 add, 2 sub, 3 div, 4 mul).
REQ-003 SHALL provide parameter DEPTH, default 2: output buffer entries, power of two, legal 2..16.
REQ-004 SHALL derive CW = clog2(NCH+1) and LW = clog2(DEPTH+1).
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 op_sel  input  NCH  per-channel select strobes, qualified by in_valid.
REQ-008 res_data  input  NCH*WIDTH  flattened channel results; channel i at bits [i*WIDTH +: WIDTH].
REQ-009 in_valid  input  1  producer offers op_sel/res_data this cycle.
REQ-010 in_ready  output  1  block accepts this cycle; high iff level < DEPTH.
REQ-011 out_data  output  WIDTH  head-of-buffer result; 0 when empty.
REQ-012 out_chan  output  CW  head-of-buffer channel index; all-ones = NONE code; 0 when empty.
REQ-013 out_valid  output  1  buffer non-empty.
REQ-014 out_ready  input  1  consumer takes head this cycle.
REQ-015 level  output  LW  current buffer occupancy.
REQ-016 err_clr  input  1  clears onehot_err (when REQ-030 feature present).
REQ-017 onehot_err  output  1  sticky multiple-select flag.

Function
REQ-018 Push SHALL occur on a rising edge where in_valid && in_ready; pop where out_valid && out_ready.
REQ-019 On push, entry SHALL hold lowest-index asserted op_sel bit i: data = channel i, chan = i.
REQ-020 On push with op_sel all zero, entry SHALL hold data = 0, chan = all-ones (NONE).
REQ-021 Pushed entry SHALL be visible at out_* the cycle after the push edge (1-cycle latency when empty).
REQ-022 Buffer SHALL be FIFO-ordered; pointers wrap modulo DEPTH.
REQ-023 Simultaneous push and pop SHALL leave level unchanged; head advances, new entry appended.
REQ-024 When full, in_ready SHALL be 0; in_ready SHALL NOT depend combinationally on out_ready.
REQ-025 When empty, pop request SHALL be ignored; out_data, out_chan SHALL read 0.
REQ-026 out_* and level SHALL be stable while out_valid=1 and out_ready=0.
REQ-027 Inputs with in_valid=0 SHALL NOT alter state, regardless of op_sel.

Reset
REQ-028 rst_n low SHALL immediately force level=0, pointers=0, out_valid=0, out_data=0, out_chan=0, onehot_err=0, in_ready=1 (DEPTH>0).
REQ-029 Reset asserted mid-stream SHALL discard all buffered entries; first edge after deassertion behaves as empty buffer.

Configuration
REQ-030 Macro RSEL_ONEHOT_CHK_EN defined: onehot_err SHALL set on any push with more than one op_sel bit asserted, remain set until a rising edge with err_clr=1; set and clear on same edge -> set wins. Selection per REQ-019 is unaffected.
REQ-031 Macro RSEL_ONEHOT_CHK_EN undefined: onehot_err SHALL be constant 0, err_clr ignored, no checker logic.

Verification
REQ-032 Defaults; push op_sel=5'b00010, add=8'h3C, out_ready=1 -> next cycle out_valid=1, out_data=8'h3C, out_chan=1; following cycle out_valid=0.
REQ-033 Push op_sel=5'b10100 (sub=8'h11, mul=8'h99) -> out_data=8'h11, out_chan=2; with RSEL_ONEHOT_CHK_EN onehot_err=1 until err_clr pulse, else 0.
REQ-034 out_ready=0, push 3 times (A5,B6,C7 on ch 0) -> after 2 pushes level=2, in_ready=0, third not accepted; release out_ready -> A5 then B6 in order.
REQ-035 Full buffer, in_valid=1 and out_ready=1 held -> one pop per cycle, in_ready returns to 1 the cycle after first pop, level never exceeds 2, no loss or duplication over 20 transfers with wrap.
REQ-036 Push op_sel=0 -> out_data=0, out_chan=3'b111; then rst_n low with 2 entries held -> out_valid=0, level=0 asynchronously, before next clk edge.

Source files
------------

// File: rtl/alu_result_sel.sv
// Priority-selects one ALU channel result per accepted cycle into a DEPTH-entry FIFO.
// Optional sticky multi-select checker is enabled by RSEL_ONEHOT_CHK_EN.
module alu_result_sel #(
  parameter int WIDTH = 8,
  parameter int NCH   = 5,
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(NCH + 1),
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       op_sel,
  input  logic [NCH*WIDTH-1:0] res_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [CW-1:0]        out_chan,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LW-1:0]        level,
  input  logic                 err_clr,
  output logic                 onehot_err
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_data [DEPTH];
  logic [CW-1:0]    mem_chan [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] sel_data;
  logic [CW-1:0]    sel_chan;

  // Scan high-to-low so the lowest asserted channel wins; no select yields the NONE code.
  always_comb begin
    sel_data = '0;
    sel_chan = '1;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (op_sel[i]) begin
        sel_data = res_data[i*WIDTH +: WIDTH];
        sel_chan = CW'(i);
      end
    end
  end

  assign in_ready  = (level < LW'(DEPTH));
  assign out_valid = (level != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
  assign out_chan  = out_valid ? mem_chan[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= sel_data;
      mem_chan[wr_ptr] <= sel_chan;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

`ifdef RSEL_ONEHOT_CHK_EN
  logic multi_sel;
  logic err_q;

  assign multi_sel = |(op_sel & (op_sel - NCH'(1)));

  // A new violation on the clearing edge takes precedence over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (push && multi_sel) begin
      err_q <= 1'b1;
    end else if (err_clr) begin
      err_q <= 1'b0;
    end
  end

  assign onehot_err = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign onehot_err     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_sel.sv
// Bench for alu_result_sel: queue-based reference model checked every cycle plus directed literal checks.
module tb_alu_result_sel;

  localparam int WIDTH = 8;
  localparam int NCH   = 5;
  localparam int DEPTH = 2;
  localparam int CW    = 3;
  localparam int LW    = 2;
`ifdef RSEL_ONEHOT_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NCH-1:0]       op_sel;
  logic [NCH*WIDTH-1:0] res_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     out_data;
  logic [CW-1:0]        out_chan;
  logic                 out_valid;
  logic                 out_ready;
  logic [LW-1:0]        level;
  logic                 err_clr;
  logic                 onehot_err;

  int n_checks = 0;
  int n_fail   = 0;

  alu_result_sel #(.WIDTH(WIDTH), .NCH(NCH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .op_sel(op_sel), .res_data(res_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .err_clr(err_clr), .onehot_err(onehot_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    c;
  } ent_t;

  ent_t q[$];
  bit   m_err;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic ent_t pick(input logic [NCH-1:0] sel, input logic [NCH*WIDTH-1:0] data);
    ent_t e;
    e.d = '0;
    e.c = 3'b111;
    for (int i = 0; i < NCH; i++) begin
      if (sel[i]) begin
        e.d = data[i*WIDTH +: WIDTH];
        e.c = CW'(i);
        return e;
      end
    end
    return e;
  endfunction

  function automatic int popcnt(input logic [NCH-1:0] v);
    int n = 0;
    for (int i = 0; i < NCH; i++) n += int'(v[i]);
    return n;
  endfunction

  // Reference model: FIFO of selected results plus sticky error flag.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_err = 1'b0;
    end else begin
      bit do_push, do_pop;
      do_push = in_valid && (q.size() < DEPTH);
      do_pop  = (q.size() > 0) && out_ready;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(pick(op_sel, res_data));
      if (CHK_EN) begin
        if (do_push && popcnt(op_sel) > 1) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_out_valid", out_valid, q.size() != 0);
    chk("cyc_out_data",  out_data,  q.size() != 0 ? q[0].d : 8'h00);
    chk("cyc_out_chan",  out_chan,  q.size() != 0 ? q[0].c : 3'b000);
    chk("cyc_level",     level,     q.size());
    chk("cyc_in_ready",  in_ready,  q.size() < DEPTH);
    chk("cyc_onehot_err", onehot_err, m_err);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op_sel = '0; res_data = '0;
    out_ready = 1'b0; err_clr = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready",  in_ready,  1'b1);
    chk("rst_level",     level,     2'd0);
    chk("rst_out_data",  out_data,  8'h00);
    chk("rst_out_chan",  out_chan,  3'b000);
    chk("rst_onehot_err", onehot_err, 1'b0);
    #20 rst_n = 1'b1;
    tick();

    // Single add result, 1-cycle latency, immediately consumed.
    out_ready = 1'b1; in_valid = 1'b1; op_sel = 5'b00010;
    res_data = {8'h00, 8'h00, 8'h00, 8'h3C, 8'h00};
    tick();
    in_valid = 1'b0;
    chk("add_valid", out_valid, 1'b1);
    chk("add_data",  out_data,  8'h3C);
    chk("add_chan",  out_chan,  3'd1);
    tick();
    chk("add_popped", out_valid, 1'b0);

    // Multiple selects: lowest index wins, checker flags it.
    in_valid = 1'b1; op_sel = 5'b10100;
    res_data = {8'h99, 8'h00, 8'h11, 8'h00, 8'h00};
    tick();
    in_valid = 1'b0;
    chk("multi_data", out_data, 8'h11);
    chk("multi_chan", out_chan, 3'd2);
    chk("multi_err",  onehot_err, CHK_EN);
    tick();
    chk("multi_err_sticky", onehot_err, CHK_EN);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_cleared", onehot_err, 1'b0);

    // Set and clear on the same edge: set wins.
    in_valid = 1'b1; err_clr = 1'b1;
    tick();
    in_valid = 1'b0; err_clr = 1'b0;
    chk("err_set_wins", onehot_err, CHK_EN);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // Idle inputs with selects asserted must not change state.
    op_sel = '1; res_data = {5{8'hEE}};
    tick(); tick();
    chk("idle_level", level, 2'd0);

    // Fill with ready low; third offer is refused.
    out_ready = 1'b0; in_valid = 1'b1; op_sel = 5'b00001;
    res_data = {32'h0, 8'hA5};
    tick();
    res_data = {32'h0, 8'hB6};
    tick();
    chk("full_level", level, 2'd2);
    chk("full_in_ready", in_ready, 1'b0);
    res_data = {32'h0, 8'hC7};
    tick();
    chk("full_refuse_level", level, 2'd2);
    chk("full_head_stable", out_data, 8'hA5);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("order_second", out_data, 8'hB6);
    tick();
    chk("order_empty", out_valid, 1'b0);

    // Streaming through a full buffer with wrap.
    out_ready = 1'b0; in_valid = 1'b1; op_sel = 5'b00001;
    res_data = {32'h0, 8'h40};
    tick();
    res_data = {32'h0, 8'h41};
    tick();
    out_ready = 1'b1;
    res_data = {32'h0, 8'h42};
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k == 0) begin
        chk("stream_in_ready_back", in_ready, 1'b1);
        chk("stream_level_after_pop", level, 2'd1);
      end
      if (in_ready) res_data = {32'h0, 8'h43 + 8'(k)};
    end
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("stream_drained", out_valid, 1'b0);

    // NONE entry, then asynchronous reset with two entries held.
    out_ready = 1'b0; in_valid = 1'b1; op_sel = 5'b00000;
    res_data = {5{8'h5A}};
    tick();
    chk("none_data", out_data, 8'h00);
    chk("none_chan", out_chan, 3'b111);
    op_sel = 5'b00001; res_data = {32'h0, 8'h55};
    tick();
    in_valid = 1'b0;
    chk("pre_rst_level", level, 2'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 1'b0);
    chk("async_rst_level", level, 2'd0);
    chk("async_rst_in_ready", in_ready, 1'b1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_empty", out_valid, 1'b0);
    in_valid = 1'b1; res_data = {32'h0, 8'h77};
    tick();
    in_valid = 1'b0;
    chk("post_rst_data", out_data, 8'h77);
    chk("post_rst_level", level, 2'd1);
    out_ready = 1'b1;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
